mem_stage_sram: RTL and testbench

Memory stage of the five-stage pipeline, placed directly downstream of the execute stage. Consumes the ALU result (used as the byte address), the forwarded store value and the memory control bits from EX/MEM. Performs loads and stores against an internal word array that models a slow SRAM with a fixed number of wait states. While an access is in flight, it drops `ready` so the hazard unit can freeze every earlier pipeline register.

---
 rtl/mem_stage_sram.sv | 156 +++++++++++++++
 tb/tb_mem_stage_sram.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/mem_stage_sram.sv
// mem_stage_sram: memory stage of the five-stage pipeline. Loads and stores
// go to an internal word array that models a slow SRAM with a fixed number of
// wait states. While an access is in flight `ready` is low so the hazard unit
// freezes the earlier pipeline registers.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   WB_EN, MEM_Read,
//   MEM_Write, dest          control bits / destination from EX/MEM
//   ALU_result               byte address (memory ops) or write-back value
//   ST_val                   forwarded store data
//   *_out                    combinational pass-through to MEM/WB
//   Mem_read_value           registered load data
//   ready                    0 = freeze pipeline
//   addr_err                 registered out-of-range flag of the last access
//   stall_count              (MEM_STALL_COUNT_EN only) cycles with ready = 0
//
// Optional feature macro: MEM_STALL_COUNT_EN
module mem_stage_sram #(
    parameter int DEPTH_WORDS = 256,
    parameter int BASE_ADDR   = 1024,
    parameter int WAIT_CYCLES = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        WB_EN,
    input  logic        MEM_Read,
    input  logic        MEM_Write,
    input  logic [4:0]  dest,
    input  logic [31:0] ALU_result,
    input  logic [31:0] ST_val,
    output logic        WB_EN_out,
    output logic        MEM_Read_out,
    output logic [4:0]  dest_out,
    output logic [31:0] ALU_result_out,
    output logic [31:0] Mem_read_value,
    output logic        ready,
    output logic        addr_err
`ifdef MEM_STALL_COUNT_EN
    ,
    output logic [31:0] stall_count
`endif
);

    localparam int          IDX_W    = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [31:0] BASE     = 32'(BASE_ADDR);
    localparam logic [31:0] DEPTH32  = 32'(DEPTH_WORDS);
    localparam logic [31:0] LAST_CNT = 32'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_t;

    state_t state, state_nxt;
    logic [31:0] cnt;

    logic [31:0] mem [DEPTH_WORDS];

    logic             lat_wr;
    logic             lat_oor;
    logic [IDX_W-1:0] lat_idx;
    logic [31:0]      lat_data;

    logic [31:0] offset;
    logic [31:0] word_idx;
    logic        req;
    logic        req_oor;
    logic        done_edge;

    assign WB_EN_out      = WB_EN;
    assign MEM_Read_out   = MEM_Read;
    assign dest_out       = dest;
    assign ALU_result_out = ALU_result;

    // Below-base addresses wrap in the subtraction, so they are caught by the
    // explicit compare rather than by the index bound.
    assign offset    = ALU_result - BASE;
    assign word_idx  = offset >> 2;
    assign req       = MEM_Read | MEM_Write;
    assign req_oor   = (ALU_result < BASE) || (word_idx >= DEPTH32);
    assign done_edge = (state == S_ACCESS) && (cnt == LAST_CNT);

    always_comb begin
        state_nxt = state;
        ready     = 1'b1;
        case (state)
            S_IDLE: begin
                if (req) begin
                    ready     = 1'b0;
                    state_nxt = S_ACCESS;
                end
            end
            S_ACCESS: begin
                ready = 1'b0;
                if (cnt == LAST_CNT)
                    state_nxt = S_DONE;
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
        // A request held on the inputs during reset must not show as a stall.
        if (rst)
            ready = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= S_IDLE;
            cnt            <= '0;
            Mem_read_value <= '0;
            addr_err       <= 1'b0;
            lat_wr         <= 1'b0;
            lat_oor        <= 1'b0;
            lat_idx        <= '0;
            lat_data       <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                S_IDLE: begin
                    if (req) begin
                        cnt      <= '0;
                        // Read+write together is a store.
                        lat_wr   <= MEM_Write;
                        lat_oor  <= req_oor;
                        lat_idx  <= word_idx[IDX_W-1:0];
                        lat_data <= ST_val;
                    end
                end
                S_ACCESS: begin
                    cnt <= cnt + 32'd1;
                    if (done_edge) begin
                        addr_err <= lat_oor;
                        if (!lat_wr)
                            Mem_read_value <= lat_oor ? 32'd0 : mem[lat_idx];
                    end
                end
                default: ;
            endcase
        end
    end

    // Array has no reset; done_edge cannot be true while reset holds IDLE,
    // so an aborted store never commits.
    always_ff @(posedge clk) begin
        if (done_edge && lat_wr && !lat_oor)
            mem[lat_idx] <= lat_data;
    end

`ifdef MEM_STALL_COUNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            stall_count <= '0;
        else if (!ready)
            stall_count <= stall_count + 32'd1;
    end
`endif

endmodule

// File: tb/tb_mem_stage_sram.sv
// Testbench for mem_stage_sram: fixed vector table, reset-abort and
// back-to-back sequences, then randomized ops against a word-array model.
module tb_mem_stage_sram;

    localparam int DEPTH = 256;
    localparam int BASE  = 1024;
    localparam int WAITC = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        WB_EN, MEM_Read, MEM_Write;
    logic [4:0]  dest;
    logic [31:0] ALU_result, ST_val;
    logic        WB_EN_out, MEM_Read_out;
    logic [4:0]  dest_out;
    logic [31:0] ALU_result_out, Mem_read_value;
    logic        ready, addr_err;
`ifdef MEM_STALL_COUNT_EN
    logic [31:0] stall_count;
`endif

    mem_stage_sram #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE), .WAIT_CYCLES(WAITC)) dut (
        .clk(clk), .rst(rst), .WB_EN(WB_EN), .MEM_Read(MEM_Read), .MEM_Write(MEM_Write),
        .dest(dest), .ALU_result(ALU_result), .ST_val(ST_val),
        .WB_EN_out(WB_EN_out), .MEM_Read_out(MEM_Read_out), .dest_out(dest_out),
        .ALU_result_out(ALU_result_out), .Mem_read_value(Mem_read_value),
        .ready(ready), .addr_err(addr_err)
`ifdef MEM_STALL_COUNT_EN
        , .stall_count(stall_count)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [31:0] ref_mem [DEPTH];
    logic [31:0] ref_rv;
    logic        ref_err;

    typedef struct {
        logic        rd, wr, wb;
        logic [4:0]  dst;
        logic [31:0] addr, data, exp_rv;
        logic        exp_err;
    } vec_t;

    vec_t tbl [15];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%h want=%h", nm, act, exp);
        end
    endtask

    // Called at posedge+1 of an IDLE cycle; returns at posedge+1 of the
    // cycle after DONE (or after the single pass-through cycle).
    task automatic run_op(input string nm, input logic rd, input logic wr, input logic wb,
                          input logic [4:0] dst, input logic [31:0] addr, input logic [31:0] data,
                          input logic [31:0] exp_rv, input logic exp_err);
        WB_EN = wb; MEM_Read = rd; MEM_Write = wr; dest = dst;
        ALU_result = addr; ST_val = data;
        #4;
        chk({nm, " alu_out"}, ALU_result_out, addr);
        chk({nm, " dest_out"}, 32'(dest_out), 32'(dst));
        chk({nm, " wb_out"}, 32'(WB_EN_out), 32'(wb));
        chk({nm, " rd_out"}, 32'(MEM_Read_out), 32'(rd));
        if (rd || wr) begin
            chk({nm, " ready c0"}, 32'(ready), 32'd0);
            for (int k = 1; k <= WAITC + 1; k++) begin
                @(posedge clk); #1;
                if (k == WAITC + 1) begin
                    MEM_Read = 1'b0; MEM_Write = 1'b0; WB_EN = 1'b0;
                end
                #3;
                chk($sformatf("%s ready c%0d", nm, k), 32'(ready), (k == WAITC + 1) ? 32'd1 : 32'd0);
            end
        end else begin
            chk({nm, " ready pass"}, 32'(ready), 32'd1);
        end
        chk({nm, " rdata"}, Mem_read_value, exp_rv);
        chk({nm, " addr_err"}, 32'(addr_err), 32'(exp_err));
        @(posedge clk); #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1);
    end

    initial begin
        int kind;
        logic [31:0] a, d;
        int idx;
        logic oor, rd, wr;

        rst = 1'b1; WB_EN = 1'b0; MEM_Read = 1'b0; MEM_Write = 1'b0;
        dest = '0; ALU_result = '0; ST_val = '0;
        #2;
        chk("reset ready", 32'(ready), 32'd1);
        chk("reset rdata", Mem_read_value, 32'd0);
        chk("reset addr_err", 32'(addr_err), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        //           rd    wr    wb    dst   addr   data          exp_rv        err
        tbl[0]  = '{1'b0, 1'b1, 1'b0, 5'd0, 1028, 32'hDEADBEEF, 32'h0,        1'b0};
        tbl[1]  = '{1'b1, 1'b0, 1'b1, 5'd3, 1028, 32'h0,        32'hDEADBEEF, 1'b0};
        tbl[2]  = '{1'b1, 1'b0, 1'b1, 5'd3, 1000, 32'h0,        32'h0,        1'b1};
        tbl[3]  = '{1'b1, 1'b0, 1'b1, 5'd3, 2048, 32'h0,        32'h0,        1'b1};
        tbl[4]  = '{1'b0, 1'b1, 1'b0, 5'd0, 1024, 32'h11111111, 32'h0,        1'b0};
        tbl[5]  = '{1'b0, 1'b1, 1'b0, 5'd0, 2048, 32'hCAFEF00D, 32'h0,        1'b1};
        tbl[6]  = '{1'b1, 1'b0, 1'b1, 5'd4, 1024, 32'h0,        32'h11111111, 1'b0};
        tbl[7]  = '{1'b1, 1'b1, 1'b0, 5'd0, 1032, 32'hA5A5A5A5, 32'h11111111, 1'b0};
        tbl[8]  = '{1'b1, 1'b0, 1'b1, 5'd5, 1032, 32'h0,        32'hA5A5A5A5, 1'b0};
        tbl[9]  = '{1'b1, 1'b0, 1'b1, 5'd5, 1029, 32'h0,        32'hDEADBEEF, 1'b0};
        tbl[10] = '{1'b1, 1'b0, 1'b1, 5'd5, 1023, 32'h0,        32'h0,        1'b1};
        tbl[11] = '{1'b0, 1'b1, 1'b0, 5'd0, 2044, 32'h0BADCAFE, 32'h0,        1'b0};
        tbl[12] = '{1'b1, 1'b0, 1'b1, 5'd6, 2047, 32'h0,        32'h0BADCAFE, 1'b0};
        tbl[13] = '{1'b0, 1'b0, 1'b1, 5'd7, 32'h55, 32'h0,      32'h0BADCAFE, 1'b0};
        tbl[14] = '{1'b1, 1'b0, 1'b1, 5'd8, 1028, 32'h0,        32'hDEADBEEF, 1'b0};

        for (int i = 0; i < 15; i++)
            run_op($sformatf("vec%0d", i), tbl[i].rd, tbl[i].wr, tbl[i].wb, tbl[i].dst,
                   tbl[i].addr, tbl[i].data, tbl[i].exp_rv, tbl[i].exp_err);

        // Reset in cycle 2 of a store to word 2 aborts it.
        WB_EN = 1'b0; MEM_Read = 1'b0; MEM_Write = 1'b1; dest = '0;
        ALU_result = 1032; ST_val = 32'h12345678;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        #2;
        chk("abort ready in rst", 32'(ready), 32'd1);
        chk("abort rdata", Mem_read_value, 32'd0);
        chk("abort addr_err", 32'(addr_err), 32'd0);
        MEM_Write = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        #3;
        chk("abort ready after", 32'(ready), 32'd1);
        @(posedge clk); #1;
`ifdef MEM_STALL_COUNT_EN
        chk("stall_count after rst", stall_count, 32'd0);
`endif
        run_op("b2b st0", 1'b0, 1'b1, 1'b0, 5'd0, 1036, 32'h01020304, 32'h0, 1'b0);
        run_op("b2b st1", 1'b0, 1'b1, 1'b0, 5'd0, 1040, 32'h05060708, 32'h0, 1'b0);
`ifdef MEM_STALL_COUNT_EN
        chk("stall_count b2b", stall_count, 32'd8);
`endif
        run_op("abort word2", 1'b1, 1'b0, 1'b1, 5'd9, 1032, 32'h0, 32'hA5A5A5A5, 1'b0);
        run_op("b2b ld1", 1'b1, 1'b0, 1'b1, 5'd9, 1040, 32'h0, 32'h05060708, 1'b0);

        // Fill the whole array so every later load has a known expectation.
        ref_rv  = 32'h05060708;
        ref_err = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            d = $urandom;
            ref_mem[i] = d;
            run_op($sformatf("fill%0d", i), 1'b0, 1'b1, 1'b0, 5'd0, 32'(BASE + 4 * i), d, ref_rv, 1'b0);
        end

        for (int n = 0; n < 150; n++) begin
            kind = int'($urandom_range(0, 3));
            if ($urandom_range(0, 1) == 0)
                a = 32'(BASE + 4 * int'($urandom_range(0, DEPTH - 1)) + int'($urandom_range(0, 3)));
            else
                a = 32'($urandom_range(BASE - 64, BASE + 4 * DEPTH + 64));
            d  = $urandom;
            rd = (kind == 1) || (kind == 3);
            wr = (kind >= 2);
            oor = (int'(a) < BASE) || ((int'(a) - BASE) / 4 >= DEPTH);
            idx = oor ? 0 : (int'(a) - BASE) / 4;
            if (rd || wr) begin
                if (wr) begin
                    if (!oor) ref_mem[idx] = d;
                end else begin
                    ref_rv = oor ? 32'd0 : ref_mem[idx];
                end
                ref_err = oor;
            end
            run_op($sformatf("rnd%0d k%0d a%0d", n, kind, a), rd, wr, 1'(kind == 0 || kind == 1),
                   5'($urandom_range(0, 31)), a, d, ref_rv, ref_err);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
